matrix_sequencer: RTL and testbench

MATRIX_SEQUENCER -- requirements
Module: matrix_sequencer

---
 rtl/matrix_sequencer_if.sv | 47 ++++
 rtl/matrix_sequencer.sv | 170 +++++++++++++++++
 tb/tb_matrix_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_sequencer_if.sv
// Bundle between matrix_sequencer and its environment: the start/result
// handshake with the consumer and the element handshake with the column
// processor.
//   master : sequencer side (drives every out_* signal)
//   slave  : environment side (consumer + column processor, drives every in_*)
// Signals:
//   in_start / in_mat_a / in_mat_b    run request and operand matrices
//   out_busy / out_done / out_mat_c   run status and result matrix
//   in_done_ack                       consumer acknowledge of out_done
//   out_proc_row / out_proc_col       operand vectors for one C element
//   out_proc_ready / out_proc_ack     start pulse and result acknowledge
//   in_proc_result / in_proc_result_ready  processor result and its valid level
interface matrix_sequencer_if #(
  parameter int unsigned size       = 4,
  parameter int unsigned cell_width = 32,
  parameter int unsigned width      = cell_width * size
);

  logic                    in_start;
  logic [width*size-1:0]   in_mat_a;
  logic [width*size-1:0]   in_mat_b;
  logic                    out_busy;
  logic                    out_done;
  logic [width*size-1:0]   out_mat_c;
  logic                    in_done_ack;
  logic [width-1:0]        out_proc_row;
  logic [width-1:0]        out_proc_col;
  logic                    out_proc_ready;
  logic [width-1:0]        in_proc_result;
  logic                    in_proc_result_ready;
  logic                    out_proc_ack;

  modport master (
    input  in_start, in_mat_a, in_mat_b, in_done_ack,
    input  in_proc_result, in_proc_result_ready,
    output out_busy, out_done, out_mat_c,
    output out_proc_row, out_proc_col, out_proc_ready, out_proc_ack
  );

  modport slave (
    output in_start, in_mat_a, in_mat_b, in_done_ack,
    output in_proc_result, in_proc_result_ready,
    input  out_busy, out_done, out_mat_c,
    input  out_proc_row, out_proc_col, out_proc_ready, out_proc_ack
  );

endinterface

// File: rtl/matrix_sequencer.sv
// Sequences C = A x B over an external column processor, one C element at a
// time in row-major order. A and B are latched at start; for each (i,j) the
// block pulses out_proc_ready with row i of A and column j of B, waits for the
// processor result, captures its low cell_width bits into C[i][j] once, and
// holds the acknowledge until the processor drops its result-ready level.
// Ports:
//   in_clk   : clock, all state changes on the rising edge
//   in_reset : asynchronous active-high reset, clears every register
//   bus      : matrix_sequencer_if master modport (handshakes and data)
module matrix_sequencer #(
  parameter int unsigned size       = 4,
  parameter int unsigned cell_width = 32,
  parameter int unsigned width      = cell_width * size
) (
  input logic                in_clk,
  input logic                in_reset,
  matrix_sequencer_if.master bus
);

  localparam int unsigned mat_w = width * size;
  localparam int unsigned idx_w = (size > 1) ? $clog2(size) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(size - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [mat_w-1:0]   a_reg;
  logic [mat_w-1:0]   b_reg;
  logic [mat_w-1:0]   c_reg;
  logic [idx_w-1:0]   row_idx;
  logic [idx_w-1:0]   col_idx;
  logic               busy;
  logic               done;
  logic               proc_ready;
  logic               proc_ack;
  logic [width-1:0]   proc_row;
  logic [width-1:0]   proc_col;

  logic [idx_w-1:0]   nxt_row;
  logic [idx_w-1:0]   nxt_col;
  logic               last_elem;

  // Only the low cell_width bits of the processor result carry data.
  logic unused_result;
  assign unused_result = ^bus.in_proc_result;

  // Row r of a row-major matrix is already a contiguous vector.
  function automatic logic [width-1:0] row_of(input logic [mat_w-1:0] m,
                                              input logic [idx_w-1:0] r);
    return m[32'(r) * width +: width];
  endfunction

  // Column c gathers element (k,c) of every row into lane k.
  function automatic logic [width-1:0] col_of(input logic [mat_w-1:0] m,
                                              input logic [idx_w-1:0] c);
    logic [width-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < size; k++) begin
      v[k * cell_width +: cell_width] = m[(k * size + 32'(c)) * cell_width +: cell_width];
    end
    return v;
  endfunction

  // Row-major successor of the current element.
  always_comb begin
    nxt_row = row_idx;
    nxt_col = col_idx + 1'b1;
    if (col_idx == last_idx) begin
      nxt_col = '0;
      nxt_row = row_idx + 1'b1;
    end
  end

  assign last_elem = (row_idx == last_idx) && (col_idx == last_idx);

  // Sequencer state and all registered outputs.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      row_idx    <= '0;
      col_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      proc_ready <= 1'b0;
      proc_ack   <= 1'b0;
      proc_row   <= '0;
      proc_col   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_start) begin
            a_reg      <= bus.in_mat_a;
            b_reg      <= bus.in_mat_b;
            c_reg      <= '0;
            row_idx    <= '0;
            col_idx    <= '0;
            busy       <= 1'b1;
            proc_ready <= 1'b1;
            // Vectors come straight from the inputs since the latch lands on this same edge.
            proc_row   <= row_of(bus.in_mat_a, '0);
            proc_col   <= col_of(bus.in_mat_b, '0);
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          proc_ready <= 1'b0;
          state      <= WAIT;
        end

        WAIT: begin
          if (bus.in_proc_result_ready) begin
            c_reg[(32'(row_idx) * size + 32'(col_idx)) * cell_width +: cell_width]
                     <= bus.in_proc_result[cell_width-1:0];
            proc_ack <= 1'b1;
            state    <= DRAIN;
          end
        end

        // Capture already happened in WAIT; here we only wait out the ready level.
        DRAIN: begin
          if (!bus.in_proc_result_ready) begin
            proc_ack <= 1'b0;
            if (last_elem) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row_idx    <= nxt_row;
              col_idx    <= nxt_col;
              proc_ready <= 1'b1;
              proc_row   <= row_of(a_reg, nxt_row);
              proc_col   <= col_of(b_reg, nxt_col);
              state      <= ISSUE;
            end
          end
        end

        DONE: begin
          if (bus.in_done_ack) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_busy       = busy;
  assign bus.out_done       = done;
  assign bus.out_mat_c      = c_reg;
  assign bus.out_proc_row   = proc_row;
  assign bus.out_proc_col   = proc_col;
  assign bus.out_proc_ready = proc_ready;
  assign bus.out_proc_ack   = proc_ack;

endmodule

// File: tb/tb_matrix_sequencer.sv
// Scoreboard bench for matrix_sequencer (size 2). Stimulus pushes the expected
// issue vectors and result matrix; independent monitors pop and compare. A
// behavioural column processor with programmable latency and hold time
// answers each issue.
module tb_matrix_sequencer;

  localparam int unsigned SIZE = 2;
  localparam int unsigned CW   = 32;
  localparam int unsigned W    = CW * SIZE;
  localparam int unsigned MW   = W * SIZE;
  localparam logic [31:0] ONE  = 32'h3F80_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_sequencer_if #(.size(SIZE), .cell_width(CW), .width(W)) bus ();

  matrix_sequencer #(.size(SIZE), .cell_width(CW), .width(W)) dut (
    .in_clk  (clk),
    .in_reset(rst),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0]   a_m [SIZE][SIZE];
  logic [31:0]   b_m [SIZE][SIZE];
  logic [W-1:0]  exp_row_q [$];
  logic [W-1:0]  exp_col_q [$];
  logic [MW-1:0] exp_c_q [$];
  logic [MW-1:0] cur_exp_c;
  int            proc_latency = 5;
  int            proc_hold    = 0;
  int            issues_seen  = 0;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic end_sim();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Processor stand-in: per-lane contribution, 1.0 passes the B element through.
  function automatic logic [31:0] lane(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h0) return 32'h0;
    if (a == ONE) return b;
    return (a * b) ^ 32'h9E37_79B9;
  endfunction

  function automatic logic [31:0] proc_fn(input logic [W-1:0] r, input logic [W-1:0] c);
    logic [31:0] acc = '0;
    for (int k = 0; k < SIZE; k++) acc ^= lane(r[k*CW +: CW], c[k*CW +: CW]);
    return acc;
  endfunction

  function automatic logic [MW-1:0] pack(input logic [31:0] m [SIZE][SIZE]);
    logic [MW-1:0] v = '0;
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) v[(i*SIZE + k)*CW +: CW] = m[i][k];
    return v;
  endfunction

  // Reference result straight from the 2-D operand arrays.
  function automatic logic [MW-1:0] model_c();
    logic [MW-1:0] c = '0;
    logic [31:0]   acc;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        acc = '0;
        for (int k = 0; k < SIZE; k++) acc ^= lane(a_m[i][k], b_m[k][j]);
        c[(i*SIZE + j)*CW +: CW] = acc;
      end
    return c;
  endfunction

  function automatic logic [31:0] rand_elem();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return ONE;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_random();
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        a_m[i][k] = rand_elem();
        b_m[i][k] = rand_elem();
      end
  endtask

  task automatic set_identity();
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        a_m[i][k] = (i == k) ? ONE : 32'h0;
        b_m[i][k] = (i == k) ? ONE : 32'h0;
      end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  MW'(bus.out_busy), '0);
    check({tag, "_done"},  MW'(bus.out_done), '0);
    check({tag, "_ready"}, MW'(bus.out_proc_ready), '0);
    check({tag, "_ack"},   MW'(bus.out_proc_ack), '0);
    check({tag, "_mat_c"}, bus.out_mat_c, '0);
    check({tag, "_row"},   MW'(bus.out_proc_row), '0);
    check({tag, "_col"},   MW'(bus.out_proc_col), '0);
  endtask

  // Push expectations for one run and pulse in_start for a single cycle.
  task automatic start_run(input bit no_wait);
    logic [W-1:0] r, c;
    if (!no_wait) @(negedge clk);
    bus.in_mat_a = pack(a_m);
    bus.in_mat_b = pack(b_m);
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        for (int k = 0; k < SIZE; k++) begin
          r[k*CW +: CW] = a_m[i][k];
          c[k*CW +: CW] = b_m[k][j];
        end
        exp_row_q.push_back(r);
        exp_col_q.push_back(c);
      end
    cur_exp_c = model_c();
    exp_c_q.push_back(cur_exp_c);
    bus.in_start = 1'b1;
    @(negedge clk);
    bus.in_start = 1'b0;
    // Operand inputs are free to change once the run has started.
    bus.in_mat_a = {$urandom, $urandom, $urandom, $urandom};
    bus.in_mat_b = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Wait for out_done, confirm it holds, acknowledge, confirm return to idle.
  task automatic finish_run(input bit b2b);
    int n = 0;
    logic [MW-1:0] expc = cur_exp_c;
    while (!bus.out_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_done) begin
      fails++;
      tests++;
      $display("FAIL done_timeout: out_done still 0 after %0d cycles", n);
      end_sim();
    end
    for (int h = 0; h < 3; h++) begin
      check("done_held", MW'(bus.out_done), MW'(1));
      check("busy_in_done", MW'(bus.out_busy), MW'(1));
      check("mat_c_stable", bus.out_mat_c, expc);
      @(negedge clk);
    end
    bus.in_done_ack = 1'b1;
    if (b2b) bus.in_start = 1'b1;
    @(negedge clk);
    bus.in_done_ack = 1'b0;
    bus.in_start    = 1'b0;
    check("done_cleared", MW'(bus.out_done), '0);
    check("busy_idle", MW'(bus.out_busy), '0);
    check("mat_c_retained", bus.out_mat_c, expc);
  endtask

  task automatic wait_issue(input int target);
    int n = 0;
    while (issues_seen < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (issues_seen < target) begin
      fails++;
      tests++;
      $display("FAIL issue_timeout: saw %0d issues, needed %0d", issues_seen, target);
      end_sim();
    end
  endtask

  // Issue monitor: every ready pulse must match the next expected (row, col).
  initial begin : issue_mon
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && bus.out_proc_ready === 1'b1) begin
        issues_seen++;
        if (exp_row_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL issue_extra: unexpected issue row %h col %h", bus.out_proc_row, bus.out_proc_col);
        end else begin
          check("issue_row", MW'(bus.out_proc_row), MW'(exp_row_q.pop_front()));
          check("issue_col", MW'(bus.out_proc_col), MW'(exp_col_q.pop_front()));
          check("issue_busy", MW'(bus.out_busy), MW'(1));
        end
      end
    end
  end

  // Result monitor: compare C on each rising out_done.
  initial begin : done_mon
    logic prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) prev_done = 1'b0;
      else begin
        if (bus.out_done === 1'b1 && !prev_done) begin
          if (exp_c_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL done_extra: unexpected out_done, mat_c %h", bus.out_mat_c);
          end else begin
            check("mat_c", bus.out_mat_c, exp_c_q.pop_front());
          end
          check("issues_left", MW'(exp_row_q.size()), '0);
        end
        prev_done = bus.out_done;
      end
    end
  end

  // Column processor model: latency, then result level held until ack plus hold cycles.
  initial begin : proc_model
    int pst = 0;
    int cnt = 0;
    logic [W-1:0] cap_row = '0, cap_col = '0;
    logic [31:0]  res = '0;
    bus.in_proc_result_ready = 1'b0;
    bus.in_proc_result       = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        pst = 0;
        bus.in_proc_result_ready = 1'b0;
      end else begin
        case (pst)
          0: if (bus.out_proc_ready === 1'b1) begin
               cap_row = bus.out_proc_row;
               cap_col = bus.out_proc_col;
               res     = proc_fn(cap_row, cap_col);
               bus.in_proc_result = {$urandom, ~res};
               if (proc_latency == 0) begin
                 bus.in_proc_result       = {$urandom, res};
                 bus.in_proc_result_ready = 1'b1;
                 pst = 2;
               end else begin
                 cnt = proc_latency;
                 pst = 1;
               end
             end
          1: begin
               check("row_stable", MW'(bus.out_proc_row), MW'(cap_row));
               check("col_stable", MW'(bus.out_proc_col), MW'(cap_col));
               cnt--;
               if (cnt == 0) begin
                 bus.in_proc_result       = {$urandom, res};
                 bus.in_proc_result_ready = 1'b1;
                 pst = 2;
               end
             end
          2: begin
               check("row_stable", MW'(bus.out_proc_row), MW'(cap_row));
               if (bus.out_proc_ack === 1'b1) begin
                 // Corrupt the data after acknowledge so any second capture shows up in C.
                 bus.in_proc_result = {$urandom, ~res};
                 if (proc_hold == 0) begin
                   bus.in_proc_result_ready = 1'b0;
                   pst = 0;
                 end else begin
                   cnt = proc_hold;
                   pst = 3;
                 end
               end
             end
          default: begin
               check("ack_held", MW'(bus.out_proc_ack), MW'(1));
               check("no_issue_in_hold", MW'(bus.out_proc_ready), '0);
               check("col_stable", MW'(bus.out_proc_col), MW'(cap_col));
               cnt--;
               if (cnt == 0) begin
                 bus.in_proc_result_ready = 1'b0;
                 pst = 0;
               end
             end
        endcase
      end
    end
  end

  initial begin : watchdog
    #300000;
    fails++;
    tests++;
    $display("FAIL watchdog: simulation time limit reached");
    end_sim();
  end

  initial begin : stim
    int base;
    bus.in_start    = 1'b0;
    bus.in_done_ack = 1'b0;
    bus.in_mat_a    = '0;
    bus.in_mat_b    = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("reset_no_clock");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Identity A against a fixed B, 5-cycle processor.
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) a_m[i][k] = (i == k) ? ONE : 32'h0;
    b_m[0][0] = 32'h4000_0000;
    b_m[0][1] = 32'h4040_0000;
    b_m[1][0] = 32'h4080_0000;
    b_m[1][1] = 32'h40A0_0000;
    proc_latency = 5;
    proc_hold    = 0;
    start_run(1'b0);
    finish_run(1'b0);
    check("c_equals_b", bus.out_mat_c, pack(b_m));

    // Processor holds its ready level 6 cycles past the acknowledge.
    set_random();
    proc_latency = 2;
    proc_hold    = 6;
    start_run(1'b0);
    finish_run(1'b0);

    // A second start during WAIT must be ignored.
    set_random();
    proc_latency = 4;
    proc_hold    = 0;
    base = issues_seen;
    start_run(1'b0);
    wait_issue(base + 1);
    @(negedge clk);
    bus.in_start = 1'b1;
    bus.in_mat_a = ~pack(a_m);
    @(negedge clk);
    bus.in_start = 1'b0;
    check("busy_after_ignored_start", MW'(bus.out_busy), MW'(1));
    finish_run(1'b0);

    // Reset during WAIT of element (1,0) abandons the run.
    set_random();
    proc_latency = 3;
    base = issues_seen;
    start_run(1'b0);
    wait_issue(base + 3);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_zero("reset_mid_run");
    exp_row_q.delete();
    exp_col_q.delete();
    exp_c_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("no_done_after_reset", MW'(bus.out_done), '0);
      check("idle_after_reset", MW'(bus.out_busy), '0);
    end
    set_identity();
    start_run(1'b0);
    finish_run(1'b0);
    check("c_identity", bus.out_mat_c, pack(a_m));

    // Back-to-back runs: start alongside ack is ignored, next-cycle start accepted.
    set_random();
    proc_latency = 1;
    start_run(1'b0);
    finish_run(1'b1);
    set_random();
    start_run(1'b1);
    finish_run(1'b0);

    // Randomised runs with varied processor timing.
    for (int r = 0; r < 8; r++) begin
      set_random();
      proc_latency = $urandom_range(0, 3);
      proc_hold    = $urandom_range(0, 3);
      start_run(1'b0);
      finish_run(r[0]);
      if (r[0]) begin
        set_random();
        start_run(1'b1);
        finish_run(1'b0);
      end
    end

    repeat (3) @(negedge clk);
    check("exp_c_drained", MW'(exp_c_q.size()), '0);
    end_sim();
  end

endmodule
